rns_fir_sequencer: RTL

RNS_FIR_SEQUENCER -- requirements
Module: rns_fir_sequencer

---
 rtl/rns_fir_sequencer.sv | 128 ++++++++++++
 1 files changed

// File: rtl/rns_fir_sequencer.sv
// Sequential FIR filter over residue-number-system samples: one multiply-accumulate
// per cycle across TAPS taps, four independent 8-bit residue lanes.
module rns_fir_sequencer #(
    parameter int TAPS = 6,
    parameter int M0   = 233,
    parameter int M1   = 239,
    parameter int M2   = 241,
    parameter int M3   = 251
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] x,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] y,
    input  logic        coef_we,
    input  logic [3:0]  coef_addr,
    input  logic [31:0] coef_data,
    output logic        busy
);

    localparam int IW = (TAPS > 1) ? $clog2(TAPS) : 1;
    localparam logic [35:0] MODS = {9'(M3), 9'(M2), 9'(M1), 9'(M0)};

    typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

    state_t          state_q, state_d;
    logic [31:0]     tap_q  [TAPS];
    logic [31:0]     tap_d  [TAPS];
    logic [31:0]     coef_q [TAPS];
    logic [31:0]     coef_d [TAPS];
    logic [31:0]     acc_q, acc_d;
    logic [31:0]     y_q, y_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [31:0]     acc_next;

    function automatic logic [31:0] addRns(input logic [31:0] a, input logic [31:0] b);
        logic [8:0]  s;
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            s = {1'b0, a[8*i +: 8]} + {1'b0, b[8*i +: 8]};
            r[8*i +: 8] = 8'(s % MODS[9*i +: 9]);
        end
        return r;
    endfunction

    // Operands may exceed the modulus; the full 16-bit product keeps the reduction exact.
    function automatic logic [31:0] mulRns(input logic [31:0] a, input logic [31:0] b);
        logic [15:0] p;
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            p = {8'b0, a[8*i +: 8]} * {8'b0, b[8*i +: 8]};
            r[8*i +: 8] = 8'(p % {7'b0, MODS[9*i +: 9]});
        end
        return r;
    endfunction

    assign acc_next = addRns(acc_q, mulRns(tap_q[idx_q], coef_q[idx_q]));

    always_comb begin
        state_d = state_q;
        tap_d   = tap_q;
        coef_d  = coef_q;
        acc_d   = acc_q;
        idx_d   = idx_q;
        y_d     = y_q;
        case (state_q)
            IDLE: begin
                if (coef_we && ({1'b0, coef_addr} < 5'(TAPS))) begin
                    coef_d[coef_addr[IW-1:0]] = coef_data;
                end
                if (in_valid) begin
                    tap_d[0] = x;
                    for (int k = 1; k < TAPS; k++) begin
                        tap_d[k] = tap_q[k-1];
                    end
                    acc_d   = '0;
                    idx_d   = '0;
                    state_d = MAC;
                end
            end
            MAC: begin
                acc_d = acc_next;
                idx_d = idx_q + 1'b1;
                if (idx_q == IW'(TAPS - 1)) begin
                    y_d     = acc_next;
                    state_d = OUT;
                end
            end
            OUT: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            acc_q   <= '0;
            y_q     <= '0;
            idx_q   <= '0;
            for (int k = 0; k < TAPS; k++) begin
                tap_q[k]  <= '0;
                coef_q[k] <= '0;
            end
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            y_q     <= y_d;
            idx_q   <= idx_d;
            tap_q   <= tap_d;
            coef_q  <= coef_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == OUT);
    assign busy      = (state_q != IDLE);
    assign y         = y_q;

endmodule
